// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer
//
// Steps an RGB LED through a six-entry colour table. Each colour fades up
// one level per PWM frame, holds at full brightness for HOLD_FRAMES frames,
// fades back down, and then advances to the next table entry.
//
// A prescaler divides clk by PRESCALE to step an 8-bit PWM phase.
// One PWM frame is 256 phase steps, which is 256*PRESCALE clocks.
// Duty registers only change at a frame boundary, so the PWM outputs never glitch.
//
// Ports
//   clk         single clock; all logic runs on its rising edge
//   rst         synchronous, active-high reset
//   enable      run request (level); dropping it returns to IDLE at once
//   skip        one-cycle pulse; ends the current colour early (FADE_UP/HOLD)
//   pwm_r/g/b   registered LED drive outputs
//   color_idx   current colour-table index, 0..5
//   state       FSM state: IDLE=0, FADE_UP=1, HOLD=2, FADE_DOWN=3, NEXT=4
//   frame_done  one-cycle pulse, one clock after each frame end while running
module rgb_fade_sequencer #(
    parameter int unsigned PRESCALE    = 391,
    parameter int unsigned HOLD_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       skip,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic [2:0] color_idx,
    output logic [2:0] state,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FADE_UP   = 3'd1,
        S_HOLD      = 3'd2,
        S_FADE_DOWN = 3'd3,
        S_NEXT      = 3'd4
    } state_e;

    localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

    state_e      state_q, state_d;
    logic [2:0]  color_q, color_d;
    logic [7:0]  level_q, level_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] pre_q;
    logic [7:0]  phase_q;
    logic [7:0]  duty_r_q, duty_g_q, duty_b_q;
    logic        pwm_r_q, pwm_g_q, pwm_b_q;
    logic        frame_done_q;

    logic        tick;
    logic        frame_end;
    logic        load_duty;
    logic [2:0]  color_bits;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'h00) ? 8'h00 : v - 8'd1;
    endfunction

    // Colour table as {r,g,b} enable bits.
    function automatic logic [2:0] table_rgb(input logic [2:0] idx);
        logic [2:0] bits;
        case (idx)
            3'd0:    bits = 3'b100;
            3'd1:    bits = 3'b110;
            3'd2:    bits = 3'b010;
            3'd3:    bits = 3'b011;
            3'd4:    bits = 3'b001;
            3'd5:    bits = 3'b101;
            default: bits = 3'b000;
        endcase
        return bits;
    endfunction

    assign tick       = (pre_q == PRE_LAST);
    // Gated with the state so PRESCALE=1 cannot produce a frame end while idle.
    assign frame_end  = tick && (phase_q == 8'hFF) && (state_q != S_IDLE);
    assign color_bits = table_rgb(color_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and level/hold/colour bookkeeping
    always_comb begin
        state_d   = state_q;
        color_d   = color_q;
        level_d   = level_q;
        hold_d    = hold_q;
        load_duty = 1'b0;

        if (!enable) begin
            // Enable has priority over skip and frame_end.
            state_d = S_IDLE;
            level_d = 8'd0;
            hold_d  = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FADE_UP;
                    level_d = 8'd0;
                end
                S_FADE_UP: begin
                    // A skip that coincides with a frame end suppresses that
                    // frame's level and duty update.
                    if (skip) begin
                        state_d = S_FADE_DOWN;
                    end else if (frame_end) begin
                        level_d   = sat_inc(level_q);
                        load_duty = 1'b1;
                        if (level_d == 8'hFF) begin
                            state_d = S_HOLD;
                            hold_d  = 8'd0;
                        end
                    end
                end
                S_HOLD: begin
                    if (skip) begin
                        state_d = S_FADE_DOWN;
                    end else if (frame_end) begin
                        hold_d    = hold_q + 8'd1;
                        load_duty = 1'b1;
                        if (hold_q == HOLD_LAST) begin
                            state_d = S_FADE_DOWN;
                        end
                    end
                end
                S_FADE_DOWN: begin
                    if (frame_end) begin
                        level_d   = sat_dec(level_q);
                        load_duty = 1'b1;
                        if (level_d == 8'h00) begin
                            state_d = S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    color_d = (color_q == 3'd5) ? 3'd0 : color_q + 3'd1;
                    state_d = S_FADE_UP;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_q <= 3'd0;
            level_q <= 8'd0;
            hold_q  <= 8'd0;
        end else begin
            color_q <= color_d;
            level_q <= level_d;
            hold_q  <= hold_d;
        end
    end

    // Prescaler and PWM phase; frozen at zero while idle so every run starts
    // from the beginning of a frame. They keep running through NEXT.
    always_ff @(posedge clk) begin
        if (rst || !enable || (state_q == S_IDLE)) begin
            pre_q   <= 16'd0;
            phase_q <= 8'd0;
        end else if (tick) begin
            pre_q   <= 16'd0;
            phase_q <= phase_q + 8'd1;
        end else begin
            pre_q   <= pre_q + 16'd1;
        end
    end

    // Duties take the level being registered in the same cycle, so the new
    // brightness starts exactly at phase 0 of the next frame.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            duty_r_q <= 8'd0;
            duty_g_q <= 8'd0;
            duty_b_q <= 8'd0;
        end else if (load_duty) begin
            duty_r_q <= color_bits[2] ? level_d : 8'd0;
            duty_g_q <= color_bits[1] ? level_d : 8'd0;
            duty_b_q <= color_bits[0] ? level_d : 8'd0;
        end
    end

    // Registered PWM compare. Duty 255 stays low at phase 255 only.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            pwm_r_q      <= 1'b0;
            pwm_g_q      <= 1'b0;
            pwm_b_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pwm_r_q      <= (state_q != S_IDLE) && (phase_q < duty_r_q);
            pwm_g_q      <= (state_q != S_IDLE) && (phase_q < duty_g_q);
            pwm_b_q      <= (state_q != S_IDLE) && (phase_q < duty_b_q);
            frame_done_q <= frame_end;
        end
    end

    // Outputs
    always_comb begin
        state      = state_q;
        color_idx  = color_q;
        pwm_r      = pwm_r_q;
        pwm_g      = pwm_g_q;
        pwm_b      = pwm_b_q;
        frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer
//
// Bench for rgb_fade_sequencer.
// Two instances share one stimulus stream:
//   u0 uses PRESCALE=1, HOLD_FRAMES=2, giving 256-clock frames.
//   u1 uses PRESCALE=2, HOLD_FRAMES=2, giving 512-clock frames.
// A behavioural model tracks each instance as a position within the frame
// plus a mode, a level and a hold count. The model predicts every output
// on every cycle.
`timescale 1ns/1ps
module tb_rgb_fade_sequencer;

    localparam int NI = 2;
    localparam int HF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic skip = 1'b0;

    logic       pwm_r0, pwm_g0, pwm_b0, fd0;
    logic [2:0] color0, state0;
    logic       pwm_r1, pwm_g1, pwm_b1, fd1;
    logic [2:0] color1, state1;

    logic [9:0] obs [NI];

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state, one entry per instance.
    int m_mode  [NI];
    int m_color [NI];
    int m_level [NI];
    int m_hold  [NI];
    int m_fpos  [NI];
    int m_fd    [NI];
    int m_duty  [NI][3];
    int m_pwm   [NI][3];

    rgb_fade_sequencer #(.PRESCALE(1), .HOLD_FRAMES(HF)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .skip(skip),
        .pwm_r(pwm_r0), .pwm_g(pwm_g0), .pwm_b(pwm_b0),
        .color_idx(color0), .state(state0), .frame_done(fd0)
    );

    rgb_fade_sequencer #(.PRESCALE(2), .HOLD_FRAMES(HF)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .skip(skip),
        .pwm_r(pwm_r1), .pwm_g(pwm_g1), .pwm_b(pwm_b1),
        .color_idx(color1), .state(state1), .frame_done(fd1)
    );

    assign obs[0] = {pwm_r0, pwm_g0, pwm_b0, color0, state0, fd0};
    assign obs[1] = {pwm_r1, pwm_g1, pwm_b1, color1, state1, fd1};

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int psc(int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // A channel is lit in three consecutive table entries:
    // red starting at 5, green starting at 1, blue starting at 3.
    function automatic bit chan_on(int color, int ch);
        int first;
        first = (ch == 0) ? 5 : ((ch == 1) ? 1 : 3);
        return ((color - first + 6) % 6) < 3;
    endfunction

    function automatic logic [9:0] expv(int i);
        return {1'(m_pwm[i][0]), 1'(m_pwm[i][1]), 1'(m_pwm[i][2]),
                3'(m_color[i]), 3'(m_mode[i]), 1'(m_fd[i])};
    endfunction

    task automatic model_step(input logic r, input logic e, input logic s);
        for (int i = 0; i < NI; i++) begin
            int  flen;
            int  nmode;
            int  ph;
            bit  fe;
            bit  load;
            flen = 256 * psc(i);
            if (r || !e) begin
                if (r) m_color[i] = 0;
                m_mode[i]  = 0;
                m_level[i] = 0;
                m_hold[i]  = 0;
                m_fpos[i]  = 0;
                m_fd[i]    = 0;
                for (int c = 0; c < 3; c++) begin
                    m_duty[i][c] = 0;
                    m_pwm[i][c]  = 0;
                end
            end else begin
                fe = (m_mode[i] != 0) && (m_fpos[i] == flen - 1);
                ph = m_fpos[i] / psc(i);
                for (int c = 0; c < 3; c++)
                    m_pwm[i][c] = (m_mode[i] != 0 && ph < m_duty[i][c]) ? 1 : 0;
                m_fd[i] = fe ? 1 : 0;
                nmode = m_mode[i];
                load  = 0;
                case (m_mode[i])
                    0: begin
                        nmode = 1;
                        m_level[i] = 0;
                    end
                    1: begin
                        if (s) nmode = 3;
                        else if (fe) begin
                            m_level[i] = (m_level[i] < 255) ? m_level[i] + 1 : 255;
                            load = 1;
                            if (m_level[i] == 255) begin
                                nmode = 2;
                                m_hold[i] = 0;
                            end
                        end
                    end
                    2: begin
                        if (s) nmode = 3;
                        else if (fe) begin
                            m_hold[i]++;
                            load = 1;
                            if (m_hold[i] == HF) nmode = 3;
                        end
                    end
                    3: begin
                        if (fe) begin
                            m_level[i] = (m_level[i] > 0) ? m_level[i] - 1 : 0;
                            load = 1;
                            if (m_level[i] == 0) nmode = 4;
                        end
                    end
                    default: begin
                        m_color[i] = (m_color[i] + 1) % 6;
                        nmode = 1;
                    end
                endcase
                if (load)
                    for (int c = 0; c < 3; c++)
                        m_duty[i][c] = chan_on(m_color[i], c) ? m_level[i] : 0;
                m_fpos[i] = (m_mode[i] == 0) ? 0 : (m_fpos[i] + 1) % flen;
                m_mode[i] = nmode;
            end
        end
    endtask

    // Apply inputs for one clock, then advance the model past that edge.
    task automatic cyc(input logic r, input logic e, input logic s);
        rst = r;
        enable = e;
        skip = s;
        @(posedge clk);
        #1;
        model_step(r, e, s);
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (obs[i] !== expv(i)) begin
                    miscompares++;
                    $display("FAIL reset_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                end
            end
            vectors++;
            if (obs[0] !== 10'd0) begin
                miscompares++;
                $display("FAIL reset_outputs t=%0t: got %b want %b", $time, obs[0], 10'd0);
            end
        end
        cyc(1'b0, 1'b1, 1'b0);
        vectors++;
        if (state0 !== 3'd1 || state1 !== 3'd1) begin
            miscompares++;
            $display("FAIL reset_release: got state %0d/%0d want 1/1", state0, state1);
        end
    endtask

    task automatic test_first_frames;
        int r0 = 0, f0 = 0, r1 = 0, gb1 = 0, f1 = 0;
        for (int k = 1; k <= 1024; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (obs[i] !== expv(i)) begin
                    miscompares++;
                    $display("FAIL first_frames_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                end
            end
            r0  += int'(pwm_r0);
            f0  += int'(fd0);
            r1  += int'(pwm_r1);
            gb1 += int'(pwm_g1 | pwm_b1);
            f1  += int'(fd1);
        end
        vectors++;
        if (r1 !== 2 || gb1 !== 0 || f1 !== 2) begin
            miscompares++;
            $display("FAIL first_frames_p2: got r=%0d gb=%0d fd=%0d want r=2 gb=0 fd=2", r1, gb1, f1);
        end
        vectors++;
        if (r0 !== 6 || f0 !== 4) begin
            miscompares++;
            $display("FAIL first_frames_p1: got r=%0d fd=%0d want r=6 fd=4", r0, f0);
        end
    endtask

    task automatic test_full_colour;
        int hold_n = 0, hold_r = 0, hold_gb = 0, guard = 0, down_r = 0;
        while (m_mode[0] != 3 && guard < 70000) begin
            cyc(1'b0, 1'b1, 1'b0);
            guard++;
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (obs[i] !== expv(i)) begin
                    miscompares++;
                    $display("FAIL full_colour_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                end
            end
            if (state0 == 3'd2) begin
                hold_n++;
                hold_r  += int'(pwm_r0);
                hold_gb += int'(pwm_g0 | pwm_b0);
            end
        end
        vectors++;
        if (guard >= 70000) begin
            miscompares++;
            $display("FAIL full_colour_timeout: got %0d cycles without FADE_DOWN, want fewer than 70000", guard);
        end
        vectors++;
        if (hold_n !== 512 || hold_r !== 510 || hold_gb !== 0) begin
            miscompares++;
            $display("FAIL hold_window: got cycles=%0d r=%0d gb=%0d want 512 510 0", hold_n, hold_r, hold_gb);
        end
        for (int k = 1; k <= 256; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (obs[i] !== expv(i)) begin
                    miscompares++;
                    $display("FAIL fade_down_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                end
            end
            down_r += int'(pwm_r0);
        end
        vectors++;
        if (down_r !== 255 || state0 !== 3'd3 || color0 !== 3'd0) begin
            miscompares++;
            $display("FAIL fade_down_first: got r=%0d state=%0d color=%0d want 255 3 0", down_r, state0, color0);
        end
        // skip has no effect while fading down
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (obs[i] !== expv(i)) begin
                miscompares++;
                $display("FAIL skip_in_down_model u%0d: got %b want %b", i, obs[i], expv(i));
            end
        end
        vectors++;
        if (state0 !== 3'd3) begin
            miscompares++;
            $display("FAIL skip_in_down: got state %0d want 3", state0);
        end
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (obs[i] !== expv(i)) begin
                miscompares++;
                $display("FAIL full_colour_stop u%0d: got %b want %b", i, obs[i], expv(i));
            end
        end
    endtask

    task automatic test_skip_colours;
        cyc(1'b0, 1'b1, 1'b0);
        for (int col = 0; col < 3; col++) begin
            int n;
            int guard;
            n = 512 + int'($urandom_range(0, 255));
            for (int k = 0; k < n; k++) begin
                cyc(1'b0, 1'b1, 1'b0);
                for (int i = 0; i < NI; i++) begin
                    vectors++;
                    if (obs[i] !== expv(i)) begin
                        miscompares++;
                        $display("FAIL skip_colours_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                    end
                end
            end
            // For colour 1 the skip lands on the frame-end cycle itself.
            guard = 0;
            while (col == 1 && m_fpos[0] != 255 && guard < 300) begin
                cyc(1'b0, 1'b1, 1'b0);
                guard++;
                for (int i = 0; i < NI; i++) begin
                    vectors++;
                    if (obs[i] !== expv(i)) begin
                        miscompares++;
                        $display("FAIL skip_align_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                    end
                end
            end
            cyc(1'b0, 1'b1, 1'b1);
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (obs[i] !== expv(i)) begin
                    miscompares++;
                    $display("FAIL skip_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                end
            end
            vectors++;
            if (state0 !== 3'd3) begin
                miscompares++;
                $display("FAIL skip_in_up col%0d: got state %0d want 3", col, state0);
            end
            guard = 0;
            while (m_color[0] == col && guard < 2048) begin
                cyc(1'b0, 1'b1, 1'b0);
                guard++;
                for (int i = 0; i < NI; i++) begin
                    vectors++;
                    if (obs[i] !== expv(i)) begin
                        miscompares++;
                        $display("FAIL skip_drain_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                    end
                end
            end
            vectors++;
            if (guard >= 2048 || color0 !== 3'(col + 1) || state0 !== 3'd1) begin
                miscompares++;
                $display("FAIL next_colour: got color=%0d state=%0d want %0d 1", color0, state0, col + 1);
            end
        end
    endtask

    task automatic test_enable_drop;
        int n, r0 = 0, g0 = 0, b0 = 0;
        n = 768 + int'($urandom_range(0, 255));
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (obs[i] !== expv(i)) begin
                    miscompares++;
                    $display("FAIL pre_drop_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                end
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        vectors++;
        if (state0 !== 3'd0 || color0 !== 3'd3 || {pwm_r0, pwm_g0, pwm_b0, fd0} !== 4'b0 || state1 !== 3'd0) begin
            miscompares++;
            $display("FAIL enable_drop: got state=%0d color=%0d pwm/fd=%b u1state=%0d want 0 3 0000 0",
                     state0, color0, {pwm_r0, pwm_g0, pwm_b0, fd0}, state1);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (obs[i] !== expv(i)) begin
                    miscompares++;
                    $display("FAIL idle_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                end
            end
        end
        cyc(1'b0, 1'b1, 1'b0);
        vectors++;
        if (state0 !== 3'd1 || color0 !== 3'd3) begin
            miscompares++;
            $display("FAIL re_enable: got state=%0d color=%0d want 1 3", state0, color0);
        end
        for (int k = 1; k < 300; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (obs[i] !== expv(i)) begin
                    miscompares++;
                    $display("FAIL re_enable_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                end
            end
            r0 += int'(pwm_r0);
            g0 += int'(pwm_g0);
            b0 += int'(pwm_b0);
        end
        vectors++;
        if (r0 !== 0 || g0 !== 1 || b0 !== 1) begin
            miscompares++;
            $display("FAIL re_enable_level0: got r=%0d g=%0d b=%0d want 0 1 1", r0, g0, b0);
        end
    endtask

    task automatic test_wrap;
        int r0 = 0, gb0 = 0;
        for (int it = 0; it < 3; it++) begin
            int n;
            int guard;
            int start;
            start = m_color[0];
            n = 256 + int'($urandom_range(0, 255));
            for (int k = 0; k < n; k++) begin
                cyc(1'b0, 1'b1, 1'b0);
                for (int i = 0; i < NI; i++) begin
                    vectors++;
                    if (obs[i] !== expv(i)) begin
                        miscompares++;
                        $display("FAIL wrap_up_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                    end
                end
            end
            cyc(1'b0, 1'b1, 1'b1);
            guard = 0;
            while (m_color[0] == start && guard < 2048) begin
                cyc(1'b0, 1'b1, 1'b0);
                guard++;
                for (int i = 0; i < NI; i++) begin
                    vectors++;
                    if (obs[i] !== expv(i)) begin
                        miscompares++;
                        $display("FAIL wrap_down_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                    end
                end
            end
            vectors++;
            if (guard >= 2048) begin
                miscompares++;
                $display("FAIL wrap_timeout: got %0d cycles without colour change, want fewer than 2048", guard);
            end
        end
        vectors++;
        if (color0 !== 3'd0 || state0 !== 3'd1) begin
            miscompares++;
            $display("FAIL wrap_colour: got color=%0d state=%0d want 0 1", color0, state0);
        end
        for (int k = 1; k < 768; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (obs[i] !== expv(i)) begin
                    miscompares++;
                    $display("FAIL wrap_fade_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                end
            end
            r0  += int'(pwm_r0);
            gb0 += int'(pwm_g0 | pwm_b0);
        end
        vectors++;
        if (r0 !== 3 || gb0 !== 0) begin
            miscompares++;
            $display("FAIL wrap_red_only: got r=%0d gb=%0d want 3 0", r0, gb0);
        end
    endtask

    task automatic test_random;
        logic en_r = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            logic r_r, s_r;
            if ($urandom_range(0, 299) == 0) en_r = ~en_r;
            if (!en_r && $urandom_range(0, 7) == 0) en_r = 1'b1;
            r_r = ($urandom_range(0, 799) == 0);
            s_r = ($urandom_range(0, 39) == 0);
            cyc(r_r, en_r, s_r);
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (obs[i] !== expv(i)) begin
                    miscompares++;
                    $display("FAIL random_model u%0d t=%0t: got %b want %b", i, $time, obs[i], expv(i));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_mode[i] = 0; m_color[i] = 0; m_level[i] = 0; m_hold[i] = 0;
            m_fpos[i] = 0; m_fd[i] = 0;
            for (int c = 0; c < 3; c++) begin
                m_duty[i][c] = 0;
                m_pwm[i][c]  = 0;
            end
        end
        test_reset;
        test_first_frames;
        test_full_colour;
        test_skip_colours;
        test_enable_drop;
        test_wrap;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rgb_fade_sequencer.md
RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 391, meaning clocks per PWM phase step, legal range 1..65535.
REQ-002 SHALL have parameter HOLD_FRAMES, default 64, meaning full-brightness frames per colour, legal range 1..255.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable  input  1  run request, level-sensitive.
REQ-006 SHALL have port skip  input  1  single-cycle pulse that ends the current colour early.
REQ-007 SHALL have ports pwm_r, pwm_g, pwm_b  output  1 each  registered LED drive.
REQ-008 SHALL have port color_idx  output  3  current colour-table index, 0..5.
REQ-009 SHALL have port state  output  3  FSM state: IDLE=0, FADE_UP=1, HOLD=2, FADE_DOWN=3, NEXT=4.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at each frame end while not IDLE.

Function
REQ-011 SHALL keep prescaler pre counting 0..PRESCALE-1 and wrapping to 0; tick = (pre==PRESCALE-1).
REQ-012 SHALL increment 8-bit phase on tick, wrapping 255->0; frame_end = tick && phase==255; one frame = 256*PRESCALE clocks.
REQ-013 SHALL hold pre and phase at 0 while in IDLE.
REQ-014 SHALL register each output as pwm_x <= (state!=IDLE) && (phase < duty_x); the output lags phase by 1 clock.
REQ-015 SHALL give duty 0 as constantly low and duty 255 as high for 255 of every 256 phases.
REQ-016 SHALL load duty_r/g/b only at frame_end, and only as table_bit(color_idx) ? level_new : 0, where level_new is the level registered that same cycle; this keeps PWM glitch-free.
REQ-017 SHALL use colour table (r,g,b): 0=(1,0,0), 1=(1,1,0), 2=(0,1,0), 3=(0,1,1), 4=(0,0,1), 5=(1,0,1).
REQ-018 SHALL go from IDLE, when enable=1, to FADE_UP on the next clock, with level=0 and the current color_idx kept.
REQ-019 SHALL, in FADE_UP, increment level by 1 at each frame_end; the frame_end that makes level 255 SHALL also move to HOLD with hold_cnt=0.
REQ-020 SHALL, in HOLD, increment hold_cnt at each frame_end; at frame_end with hold_cnt==HOLD_FRAMES-1 SHALL move to FADE_DOWN.
REQ-021 SHALL, in FADE_DOWN, decrement level by 1 at each frame_end; the frame_end that makes level 0 SHALL also move to NEXT.
REQ-022 SHALL spend exactly one clock in NEXT, advancing color_idx (5 wraps to 0), then move to FADE_UP; pre and phase keep running through NEXT.
REQ-023 SHALL saturate level arithmetic at 0 and 255; level never wraps.
REQ-024 SHALL treat skip=1 in FADE_UP or HOLD as a move to FADE_DOWN on the next clock, level unchanged; skip wins over a coincident frame_end, with no level or duty change that cycle.
REQ-025 SHALL ignore skip in IDLE, FADE_DOWN and NEXT.
REQ-026 SHALL, on enable=0 in any non-IDLE state, go next clock to: IDLE, level=0, hold_cnt=0, pre=0, phase=0, duties=0, pwm_x=0 and frame_done=0, with color_idx retained.
REQ-027 SHALL give enable=0 priority over skip and frame_end.
REQ-028 SHALL assert frame_done for exactly the frame_end cycle +1 clock (registered).

Reset
REQ-029 SHALL, while rst=1 at a clock edge, set state=IDLE, color_idx=0, level=0, hold_cnt=0, pre=0, phase=0, duties=0, pwm_r/g/b=0 and frame_done=0.
REQ-030 SHALL give rst priority over enable and skip, apply it mid-operation, and ignore enable until the first clock with rst=0.

Verification (PRESCALE=2, HOLD_FRAMES=2, frame=512 clocks)
REQ-031 SHALL cover reset: rst=1 for 3 clocks with enable=1 -> all outputs 0, state=0, color_idx=0; state=1 one clock after rst falls.
REQ-032 SHALL cover the first frame: enable at t0 -> pwm all 0 for frame 1; frame 2 has pwm_r high exactly 2 clocks at phase 0, pwm_g=pwm_b=0; frame_done pulses every 512 clocks.
REQ-033 SHALL cover one full colour: color 0 gives 255 frames FADE_UP, 2 frames HOLD (pwm_r high 510/512 clocks), 255 frames FADE_DOWN, 1 clock NEXT -> color_idx=1, and pwm_r and pwm_g both ramp thereafter.
REQ-034 SHALL cover wrap: colour 5 completes -> color_idx=0, and only pwm_r is active in the following fade.
REQ-035 SHALL cover skip: a skip pulse in HOLD at level 255 -> state=3 next clock, and duty steps 254, 253, ... on subsequent frame_ends; skip in FADE_DOWN -> no effect.
REQ-036 SHALL cover enable drop: enable=0 in FADE_UP at level 100, color 3 -> next clock state=0, pwm all 0, color_idx=3; re-enable -> FADE_UP from level 0 at color 3.
